// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO built on a single-port asynchronous-read SRAM plus one output register.
// Reads and writes share the SRAM address, so each cycle carries at most one access and refilling the output register takes priority.
module sram_fifo_ctrl #(
   parameter int DATA_W = 2,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_valid,
   input  logic [DATA_W-1:0] push_data,
   output logic              push_ready,
   output logic              pop_valid,
   output logic [DATA_W-1:0] pop_data,
   input  logic              pop_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W:0]   LP_DEPTH   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   LP_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] LP_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_mem_cnt;
   logic              r_pop_valid;
   logic [DATA_W-1:0] r_pop_data;

   logic w_out_free;
   logic w_mem_empty;
   logic w_rd_sel;
   logic w_byp;
   logic w_push_ready;
   logic w_mem_we;

   // A read is needed whenever the output register is free and memory holds the next word.
   assign w_out_free   = !r_pop_valid || pop_ready;
   assign w_mem_empty  = (r_mem_cnt == '0);
   assign w_rd_sel     = w_out_free && !w_mem_empty;
   assign w_byp        = w_out_free && w_mem_empty;
   assign w_push_ready = !w_rd_sel && (r_mem_cnt != LP_DEPTH);
   assign w_mem_we     = push_valid && w_push_ready && !w_byp;

   assign push_ready = w_push_ready;
   assign pop_valid  = r_pop_valid;
   assign pop_data   = r_pop_data;
   assign mem_we     = w_mem_we;
   assign mem_addr   = w_rd_sel ? r_rd_ptr : r_wr_ptr;
   assign mem_wdata  = push_data;
   assign count      = r_mem_cnt + {{ADDR_W{1'b0}}, r_pop_valid};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_mem_cnt   <= '0;
         r_pop_valid <= 1'b0;
         r_pop_data  <= '0;
      end else begin
         if (w_rd_sel) begin
            r_pop_data  <= mem_rdata;
            r_pop_valid <= 1'b1;
            r_rd_ptr    <= r_rd_ptr + LP_PTR_ONE;
         end else if (w_byp && push_valid) begin
            r_pop_data  <= push_data;
            r_pop_valid <= 1'b1;
         end else if (w_out_free) begin
            r_pop_valid <= 1'b0;
         end

         if (w_mem_we) begin
            r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
         end

         // rd_sel and mem_we never coincide, so the count moves by at most one.
         if (w_rd_sel) begin
            r_mem_cnt <= r_mem_cnt - LP_CNT_ONE;
         end else if (w_mem_we) begin
            r_mem_cnt <= r_mem_cnt + LP_CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: behavioural SRAM, handshake scoreboard, and scenario tasks.
module tb_sram_fifo_ctrl;

   localparam int DATA_W = 2;
   localparam int ADDR_W = 2;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              push_valid = 1'b0;
   logic [DATA_W-1:0] push_data = '0;
   logic              push_ready;
   logic              pop_valid;
   logic [DATA_W-1:0] pop_data;
   logic              pop_ready = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W:0]   count;

   logic [DATA_W-1:0] sram [DEPTH];

   int n_checks = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] q [$];

   sram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_valid(push_valid),
      .push_data (push_data),
      .push_ready(push_ready),
      .pop_valid (pop_valid),
      .pop_data  (pop_data),
      .pop_ready (pop_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .count     (count)
   );

   always #5 clk = ~clk;

   assign mem_rdata = sram[mem_addr];
   always @(posedge clk) if (mem_we) sram[mem_addr] <= mem_wdata;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: sampled mid-cycle while inputs are stable; pops checked before pushes are queued.
   always @(negedge clk) begin
      if (rst_n) begin
         automatic int  held  = q.size();
         automatic bit  e_pv  = (held != 0);
         automatic bit  e_fr  = !e_pv || pop_ready;
         automatic int  memc  = held - (e_pv ? 1 : 0);
         automatic bit  e_pr  = !(e_fr && memc != 0) && (memc != DEPTH);
         automatic bit  e_we  = push_valid && e_pr && !(e_fr && memc == 0);
         n_checks++;
         if (int'(count) !== held) begin
            n_fail++;
            $display("FAIL sb_count: got %0d expected %0d", count, held);
         end
         n_checks++;
         if (pop_valid !== e_pv) begin
            n_fail++;
            $display("FAIL sb_pop_valid: got %0b expected %0b", pop_valid, e_pv);
         end
         n_checks++;
         if (push_ready !== e_pr) begin
            n_fail++;
            $display("FAIL sb_push_ready: got %0b expected %0b", push_ready, e_pr);
         end
         n_checks++;
         if (mem_we !== e_we) begin
            n_fail++;
            $display("FAIL sb_mem_we: got %0b expected %0b", mem_we, e_we);
         end
         if (pop_valid && pop_ready && q.size() != 0) begin
            automatic logic [DATA_W-1:0] exp = q.pop_front();
            n_checks++;
            if (pop_data !== exp) begin
               n_fail++;
               $display("FAIL sb_pop_data: got %0d expected %0d", pop_data, exp);
            end
         end
         if (push_valid && push_ready) q.push_back(push_data);
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      push_valid = 1'b0;
      pop_ready = 1'b0;
      tick();
      tick();
      n_checks++;
      if (pop_valid !== 1'b0 || count !== 3'd0 || pop_data !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: got pv=%0b cnt=%0d pd=%0d expected pv=0 cnt=0 pd=0", pop_valid, count, pop_data);
      end
      n_checks++;
      if (push_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got pr=%0b we=%0b addr=%0d expected pr=1 we=0 addr=0", push_ready, mem_we, mem_addr);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_bypass();
      push_valid = 1'b1;
      push_data  = 2'b10;
      pop_ready  = 1'b1;
      #1;
      n_checks++;
      if (mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL bypass_we: got %0b expected 0", mem_we);
      end
      tick();
      push_valid = 1'b0;
      pop_ready  = 1'b0;
      #1;
      n_checks++;
      if (pop_valid !== 1'b1 || pop_data !== 2'b10 || count !== 3'd1) begin
         n_fail++;
         $display("FAIL bypass_out: got pv=%0b pd=%0d cnt=%0d expected pv=1 pd=2 cnt=1", pop_valid, pop_data, count);
      end
      pop_ready = 1'b1;
      tick();
      pop_ready = 1'b0;
   endtask

   task automatic test_fill();
      logic [1:0] vals [5];
      vals = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      pop_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_valid = 1'b1;
         push_data  = vals[i];
         #1;
         n_checks++;
         if (i == 0 && mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_first_we: got %0b expected 0", mem_we);
         end else if (i != 0 && (mem_we !== 1'b1 || int'(mem_addr) !== i - 1)) begin
            n_fail++;
            $display("FAIL fill_write: got we=%0b addr=%0d expected we=1 addr=%0d", mem_we, mem_addr, i - 1);
         end
         tick();
      end
      push_data = 2'd3;
      #1;
      n_checks++;
      if (count !== 3'd5 || push_ready !== 1'b0 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL full_state: got cnt=%0d pr=%0b we=%0b expected cnt=5 pr=0 we=0", count, push_ready, mem_we);
      end
      tick();
      n_checks++;
      if (count !== 3'd5 || pop_data !== 2'd1) begin
         n_fail++;
         $display("FAIL full_held: got cnt=%0d pd=%0d expected cnt=5 pd=1", count, pop_data);
      end
      push_valid = 1'b0;
   endtask

   task automatic test_drain();
      logic [1:0] seq [5];
      seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      pop_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if (pop_valid !== 1'b1 || pop_data !== seq[i]) begin
            n_fail++;
            $display("FAIL drain_data[%0d]: got pv=%0b pd=%0d expected pv=1 pd=%0d", i, pop_valid, pop_data, seq[i]);
         end
         n_checks++;
         if (push_ready !== (i == 4)) begin
            n_fail++;
            $display("FAIL drain_ready[%0d]: got %0b expected %0b", i, push_ready, (i == 4));
         end
         tick();
      end
      n_checks++;
      if (count !== 3'd0 || pop_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_empty: got cnt=%0d pv=%0b expected cnt=0 pv=0", count, pop_valid);
      end
      pop_ready = 1'b0;
   endtask

   task automatic test_wrap();
      int npush = 0;
      int npop  = 0;
      int nwr   = 0;
      // Four earlier writes and four reads leave both pointers back at 0.
      for (int cyc = 0; cyc < 200 && npop < 10; cyc++) begin
         pop_ready  = cyc[0];
         push_valid = (npush < 10);
         push_data  = 2'(npush % 4);
         #1;
         if (mem_we) begin
            n_checks++;
            if (int'(mem_addr) !== nwr % 4) begin
               n_fail++;
               $display("FAIL wrap_waddr: got %0d expected %0d", mem_addr, nwr % 4);
            end
            nwr++;
         end
         if (pop_valid && pop_ready) begin
            n_checks++;
            if (int'(pop_data) !== npop % 4) begin
               n_fail++;
               $display("FAIL wrap_order[%0d]: got %0d expected %0d", npop, pop_data, npop % 4);
            end
            npop++;
         end
         if (push_valid && push_ready) npush++;
         tick();
      end
      n_checks++;
      if (npop != 10) begin
         n_fail++;
         $display("FAIL wrap_timeout: got %0d pops expected 10", npop);
      end
      n_checks++;
      if (nwr < DEPTH + 1) begin
         n_fail++;
         $display("FAIL wrap_no_wrap: got %0d writes expected at least %0d", nwr, DEPTH + 1);
      end
      push_valid = 1'b0;
      pop_ready  = 1'b0;
   endtask

   task automatic test_back_to_back();
      push_valid = 1'b1;
      push_data  = 2'd3;
      pop_ready  = 1'b0;
      tick();
      push_data = 2'd2;
      pop_ready = 1'b1;
      #1;
      n_checks++;
      if (mem_we !== 1'b0 || push_ready !== 1'b1 || count !== 3'd1) begin
         n_fail++;
         $display("FAIL b2b_comb: got we=%0b pr=%0b cnt=%0d expected we=0 pr=1 cnt=1", mem_we, push_ready, count);
      end
      tick();
      push_valid = 1'b0;
      #1;
      n_checks++;
      if (pop_valid !== 1'b1 || pop_data !== 2'd2 || count !== 3'd1) begin
         n_fail++;
         $display("FAIL b2b_out: got pv=%0b pd=%0d cnt=%0d expected pv=1 pd=2 cnt=1", pop_valid, pop_data, count);
      end
      tick();
      pop_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [1:0] vals [3];
      vals = '{2'd1, 2'd2, 2'd3};
      pop_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_valid = 1'b1;
         push_data  = vals[i];
         tick();
      end
      push_valid = 1'b0;
      #1;
      n_checks++;
      if (count !== 3'd3) begin
         n_fail++;
         $display("FAIL areset_pre: got cnt=%0d expected 3", count);
      end
      #1;
      rst_n = 1'b0;
      q.delete();
      #1;
      n_checks++;
      if (pop_valid !== 1'b0 || count !== 3'd0 || push_ready !== 1'b1 || mem_addr !== 2'd0) begin
         n_fail++;
         $display("FAIL areset_now: got pv=%0b cnt=%0d pr=%0b addr=%0d expected pv=0 cnt=0 pr=1 addr=0", pop_valid, count, push_ready, mem_addr);
      end
      tick();
      rst_n = 1'b1;
      tick();
      push_valid = 1'b1;
      push_data  = 2'd1;
      #1;
      n_checks++;
      if (mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_bypass_we: got %0b expected 0", mem_we);
      end
      tick();
      push_valid = 1'b0;
      #1;
      n_checks++;
      if (pop_valid !== 1'b1 || pop_data !== 2'd1 || count !== 3'd1) begin
         n_fail++;
         $display("FAIL areset_bypass: got pv=%0b pd=%0d cnt=%0d expected pv=1 pd=1 cnt=1", pop_valid, pop_data, count);
      end
      pop_ready = 1'b1;
      tick();
      pop_ready = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_fill();
      test_drain();
      test_wrap();
      test_back_to_back();
      test_async_reset();
      n_checks++;
      if (q.size() != 0 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL final_empty: got q=%0d cnt=%0d expected 0", q.size(), count);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
